frame_dump_seq: RTL and testbench

Readout sequencer for the downsampled frame buffer. It sits downstream of the downsample block's read port and upstream of the UART transmitter, all in the 12 MHz system clock domain. A debounced button press starts a raster dump: one UART byte per buffer pixel, paced by the UART busy flag plus a holdoff gap.

---
 rtl/frame_dump_seq.sv | 190 +++++++++++++++++++
 tb/tb_frame_dump_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dump_seq.sv
// frame_dump_seq
// Readout sequencer for the downsampled frame buffer. A debounced button press
// starts a raster dump. Each buffer pixel becomes one UART byte, with x varying
// fastest. Consecutive bytes are separated by the UART busy time plus a
// holdoff gap.
//
// Optional build macro: FRAME_DUMP_HEADER_EN
//   When defined, each dump starts with the two header bytes 0xA5 and 0x5A.
//
// Ports:
//   clk        system clock (12 MHz)
//   areset_n   asynchronous active-low reset
//   btn        raw trigger button, active high, asynchronous
//   read_x     buffer read column
//   read_y     buffer read row
//   read_data  buffer read data, valid one clock after the address is stable
//   uart_busy  UART is transmitting
//   uart_wr    one-cycle write strobe to the UART
//   uart_dat   byte to send, stable while uart_wr is high
//   busy       a dump is in progress
//   frame_done one-cycle pulse in the cycle the last byte strobe is high
module frame_dump_seq #(
  parameter int WIDTH         = 40,
  parameter int HEIGHT        = 30,
  parameter int X_BITS        = 6,
  parameter int Y_BITS        = 5,
  parameter int DEBOUNCE_BITS = 14,
  parameter int HOLDOFF_BITS  = 13
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              btn,
  output logic [X_BITS-1:0] read_x,
  output logic [Y_BITS-1:0] read_y,
  input  logic [7:0]        read_data,
  input  logic              uart_busy,
  output logic              uart_wr,
  output logic [7:0]        uart_dat,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WAIT,
    ST_DONE,
    ST_HDR0,
    ST_HDR1
  } state_t;

  state_t                   state, state_next;
  logic                     btn_meta, btn_s;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic [HOLDOFF_BITS-1:0]  hold_cnt;
  logic                     armed;

  logic       trigger, ready, x_last, y_last;
  logic       wr_fire, addr_clear, addr_step, dat_we;
  logic [7:0] dat_next;

  assign trigger = (&deb_cnt) && armed && (state == ST_IDLE);
  // uart_wr is included so the cycle of the strobe itself can never start another byte.
  assign ready   = (&hold_cnt) && !uart_busy && !uart_wr;
  assign x_last  = (read_x == X_BITS'(WIDTH - 1));
  assign y_last  = (read_y == Y_BITS'(HEIGHT - 1));

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  // NOTE: every output of this block is given a default first, so a path
  // through the case that does not mention a signal cannot infer a latch.
  always_comb begin
    state_next = state;
    wr_fire    = 1'b0;
    addr_clear = 1'b0;
    addr_step  = 1'b0;
    dat_we     = 1'b0;
    dat_next   = read_data;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          addr_clear = 1'b1;
`ifdef FRAME_DUMP_HEADER_EN
          state_next = ST_HDR0;
`else
          state_next = ST_FETCH;
`endif
        end
      end
`ifdef FRAME_DUMP_HEADER_EN
      ST_HDR0: begin
        if (ready) begin
          wr_fire    = 1'b1;
          dat_we     = 1'b1;
          dat_next   = 8'hA5;
          state_next = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (ready) begin
          wr_fire    = 1'b1;
          dat_we     = 1'b1;
          dat_next   = 8'h5A;
          state_next = ST_FETCH;
        end
      end
`endif
      // The RAM samples the address at the end of FETCH, so its data is
      // present on read_data during LOAD.
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD: begin
        dat_we     = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (ready) begin
          wr_fire    = 1'b1;
          addr_step  = 1'b1;
          state_next = (x_last && y_last) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        addr_clear = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop in this
  // block samples the values from before the clock edge.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= ST_IDLE;
      uart_wr  <= 1'b0;
      uart_dat <= 8'h00;
      read_x   <= '0;
      read_y   <= '0;
    end else begin
      state   <= state_next;
      uart_wr <= wr_fire;
      if (dat_we) uart_dat <= dat_next;
      if (addr_clear) begin
        read_x <= '0;
        read_y <= '0;
      end else if (addr_step) begin
        if (x_last) begin
          read_x <= '0;
          // After the final pixel, wrap to row 0 so the address never leaves the buffer.
          read_y <= y_last ? '0 : read_y + Y_BITS'(1);
        end else begin
          read_x <= read_x + X_BITS'(1);
        end
      end
    end
  end

  // Button synchroniser, debounce counter and re-arm flag. The flag ensures a
  // held button produces exactly one dump.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      deb_cnt  <= '0;
      armed    <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
      if (!btn_s)          deb_cnt <= '0;
      else if (!(&deb_cnt)) deb_cnt <= deb_cnt + DEBOUNCE_BITS'(1);
      if (!btn_s)          armed <= 1'b1;
      else if (trigger)    armed <= 1'b0;
    end
  end

  // Holdoff counter. It counts the idle time on the UART since its last
  // activity, and saturates at all-ones.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      hold_cnt <= '0;
    end else if (uart_busy || uart_wr) begin
      hold_cnt <= '0;
    end else if (!(&hold_cnt)) begin
      hold_cnt <= hold_cnt + HOLDOFF_BITS'(1);
    end
  end

endmodule

// File: tb/tb_frame_dump_seq.sv
module tb_frame_dump_seq;
  // Small geometry and counters keep a full dump to a few hundred cycles.
  localparam int W  = 5;
  localparam int H  = 3;
  localparam int XB = 3;
  localparam int YB = 2;
  localparam int DB = 6;
  localparam int HB = 4;
  localparam int UB = 10;   // UART busy cycles after each strobe
`ifdef FRAME_DUMP_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int N = W * H + HDR;

  logic          clk = 1'b0;
  logic          areset_n = 1'b0;
  logic          btn = 1'b0;
  logic [7:0]    read_data = 8'h00;
  logic          uart_busy = 1'b0;
  logic [XB-1:0] read_x;
  logic [YB-1:0] read_y;
  logic          uart_wr;
  logic [7:0]    uart_dat;
  logic          busy;
  logic          frame_done;

  frame_dump_seq #(
    .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB),
    .DEBOUNCE_BITS(DB), .HOLDOFF_BITS(HB)
  ) dut (
    .clk(clk), .areset_n(areset_n), .btn(btn),
    .read_x(read_x), .read_y(read_y), .read_data(read_data),
    .uart_busy(uart_busy), .uart_wr(uart_wr), .uart_dat(uart_dat),
    .busy(busy), .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment models and monitor state
  bit         model_en = 1'b0;
  logic [7:0] bytes_q[$];
  int         fd_count = 0, fd_at = 0, double_wr = 0, addr_oob = 0;
  int         min_gap = 1000000, gap_ctr = 0, busy_cnt = 0;
  bit         prev_wr = 1'b0, prev_ub = 1'b0, gap_armed = 1'b0;
  logic [XB-1:0] px = '0;
  logic [YB-1:0] py = '0;

  // The RAM returns data for the address seen one cycle earlier. The UART
  // stays busy for UB cycles after each strobe. The monitor records every
  // byte written, the frame_done pulses and the pacing gaps.
  initial forever begin
    @(negedge clk);
    if (model_en) begin
      read_data = 8'((int'(px) * 7 + int'(py)) % 256);
      px = read_x;
      py = read_y;
      if (uart_wr) busy_cnt = UB;
      else if (busy_cnt > 0) busy_cnt--;
      uart_busy = (busy_cnt != 0);
    end
    if (int'(read_x) >= W || int'(read_y) >= H) addr_oob++;
    if (uart_wr) begin
      bytes_q.push_back(uart_dat);
      if (prev_wr) double_wr++;
      if (gap_armed) begin
        if (gap_ctr < min_gap) min_gap = gap_ctr;
        gap_armed = 1'b0;
      end
    end
    if (frame_done) begin
      fd_count++;
      fd_at = bytes_q.size();
    end
    if (prev_ub && !uart_busy) begin
      gap_armed = 1'b1;
      gap_ctr   = 0;
    end
    if (gap_armed) gap_ctr++;
    prev_wr = uart_wr;
    prev_ub = uart_busy;
  end

  function automatic logic [7:0] exp_byte(input int i);
    int k;
    if (HDR == 2 && i == 0) return 8'hA5;
    if (HDR == 2 && i == 1) return 8'h5A;
    k = i - HDR;
    return 8'(((k % W) * 7 + (k / W)) % 256);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int start_fd, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (fd_count > start_fd) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic check_dump(input string name);
    checks++;
    if (bytes_q.size() !== N) begin
      errors++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, bytes_q.size(), N);
    end
    for (int i = 0; i < bytes_q.size() && i < N; i++) begin
      checks++;
      if (bytes_q[i] !== exp_byte(i)) begin
        errors++;
        $display("FAIL %s byte[%0d]: got %02h expected %02h", name, i, bytes_q[i], exp_byte(i));
      end
    end
  endtask

  task automatic test_reset;
    bit bad = 1'b0;
    areset_n = 1'b0;
    model_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn       = 1'($urandom);
      uart_busy = 1'($urandom);
      read_data = 8'($urandom);
      tick(1);
      if (read_x !== '0 || read_y !== '0 || uart_wr !== 1'b0 || uart_dat !== 8'h00 ||
          busy !== 1'b0 || frame_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero during reset, expected all 0");
    end
    btn = 1'b0; uart_busy = 1'b0; read_data = 8'h00;
    busy_cnt = 0; model_en = 1'b1;
    areset_n = 1'b1;
    bytes_q.delete();
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bytes_q.size() !== 0) begin
      errors++;
      $display("FAIL idle_no_wr: got %0d writes expected 0", bytes_q.size());
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: busy rose while idle, expected 0");
    end
  endtask

  task automatic test_debounce;
    bit early = 1'b0;
    bit seen  = 1'b0;
    int cnt   = 0;
    for (int p = 0; p < 3; p++) begin
      btn = 1'b1;
      for (int i = 0; i < 30; i++) begin tick(1); if (busy) early = 1'b1; end
      btn = 1'b0;
      for (int i = 0; i < 30; i++) begin tick(1); if (busy) early = 1'b1; end
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse: busy rose on a short pulse, expected no trigger");
    end
    bytes_q.delete();
    btn = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      cnt++;
      if (busy) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || cnt < (1 << DB) - 1 || cnt > (1 << DB) + 2) begin
      errors++;
      $display("FAIL debounce_latency: got %0d cycles (seen=%0d) expected %0d..%0d",
               cnt, seen, (1 << DB) - 1, (1 << DB) + 2);
    end
  endtask

  task automatic test_raster;
    bit ok;
    wait_frame(0, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL raster_timeout: frame_done not seen, expected one pulse");
    end
    tick(2);
    check_dump("raster");
    checks++;
    if (fd_count !== 1 || fd_at !== N) begin
      errors++;
      $display("FAIL frame_done: got count %0d at byte %0d expected 1 at %0d", fd_count, fd_at, N);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %0b expected 0", busy);
    end
  endtask

  task automatic test_pacing;
    checks++;
    if (min_gap < (1 << HB) - 1 || min_gap >= 1000000) begin
      errors++;
      $display("FAIL holdoff_gap: got min %0d expected >= %0d", min_gap, (1 << HB) - 1);
    end
    checks++;
    if (double_wr !== 0) begin
      errors++;
      $display("FAIL double_wr: got %0d back-to-back strobes expected 0", double_wr);
    end
    checks++;
    if (addr_oob !== 0) begin
      errors++;
      $display("FAIL addr_range: got %0d out-of-range samples expected 0", addr_oob);
    end
  endtask

  task automatic test_hold_no_retrigger;
    bit rose = 1'b0;
    for (int i = 0; i < 300; i++) begin tick(1); if (busy) rose = 1'b1; end
    checks++;
    if (rose !== 1'b0 || bytes_q.size() !== N || fd_count !== 1) begin
      errors++;
      $display("FAIL held_button: got busy=%0b bytes=%0d frames=%0d expected 0/%0d/1",
               rose, bytes_q.size(), fd_count, N);
    end
  endtask

  task automatic test_retrigger;
    bit ok;
    int start_fd;
    btn = 1'b0;
    tick(20);
    bytes_q.delete();
    start_fd = fd_count;
    btn = 1'b1;
    wait_frame(start_fd, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL retrigger_timeout: frame_done not seen, expected a second dump");
    end
    tick(2);
    check_dump("retrigger");
    btn = 1'b0;
    tick(20);
  endtask

  task automatic test_reset_mid_dump;
    bit ok;
    bit reached = 1'b0;
    int start_fd;
    bytes_q.delete();
    btn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (bytes_q.size() >= 7) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL mid_dump_timeout: got %0d bytes expected 7", bytes_q.size());
    end
    areset_n = 1'b0;
    #1;
    checks++;
    if (read_x !== '0 || read_y !== '0 || uart_wr !== 1'b0 || uart_dat !== 8'h00 ||
        busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d wr=%0b dat=%02h busy=%0b done=%0b expected all 0",
               read_x, read_y, uart_wr, uart_dat, busy, frame_done);
    end
    btn = 1'b0;
    tick(3);
    areset_n = 1'b1;
    tick(20);
    bytes_q.delete();
    start_fd = fd_count;
    btn = 1'b1;
    wait_frame(start_fd, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_timeout: frame_done not seen, expected a fresh dump");
    end
    tick(2);
    check_dump("post_reset");
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_raster();
    test_pacing();
    test_hold_no_retrigger();
    test_retrigger();
    test_reset_mid_dump();
    test_pacing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
